fixed_linear_bias_add_cast: RTL
===============================

Name: fixed_linear_bias_add_cast

Overview:
- Streaming stage directly downstream of the per-layer bias source blocks, such as the attention output dense bias source.
- Joins the linear-layer matmul result stream with the bias stream and adds them element-wise in fixed point.
- Rounds and saturates the sum to the layer output precision, then forwards it with valid/ready handshake.
- Tracks tensor position so the bias beat and data beat are always column-aligned, and flags the last beat of each tensor.

Parameters:
- DATA_IN_PRECISION_0, 32, data_in total width (signed).
- DATA_IN_PRECISION_1, 12, data_in fractional bits.
- BIAS_PRECISION_0, 16, bias total width (signed).
- BIAS_PRECISION_1, 3, bias fractional bits; must be <= DATA_IN_PRECISION_1.
- DATA_OUT_PRECISION_0, 16, output total width (signed).
- DATA_OUT_PRECISION_1, 3, output fractional bits; must be <= DATA_IN_PRECISION_1.
- PARALLELISM, 1, elements per beat on every stream.
- TENSOR_SIZE_DIM_0, 32, columns per row; must be a multiple of PARALLELISM.
- TENSOR_SIZE_DIM_1, 4, rows per tensor.
- COL_BEATS, TENSOR_SIZE_DIM_0/PARALLELISM, derived; equals the bias source depth.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset.
- data_in, in, [PARALLELISM-1:0] x DATA_IN_PRECISION_0, matmul results.
- data_in_valid, in, 1.
- data_in_ready, out, 1.
- bias, in, [PARALLELISM-1:0] x BIAS_PRECISION_0, bias beat from bias source.
- bias_valid, in, 1.
- bias_ready, out, 1.
- data_out, out, [PARALLELISM-1:0] x DATA_OUT_PRECISION_0, biased result.
- data_out_valid, out, 1.
- data_out_ready, in, 1.
- data_out_last, out, 1, high on final beat of tensor (row TENSOR_SIZE_DIM_1-1, col beat COL_BEATS-1).
- sat_flag, out, 1, sticky: some element saturated since reset.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: both pipeline valids=0, data_out=0, data_out_last=0, sat_flag=0, col/row counters=0. Reset mid-stream discards in-flight beats.
- Join: fire = data_in_valid & bias_valid & s1_ready.
  - data_in_ready = bias_valid & s1_ready; bias_ready = data_in_valid & s1_ready.
  - Both beats are consumed in the same cycle, never one alone.
  - Neither ready depends combinationally on its own valid.
- Pipeline: 2 register stages.
  - S1 holds the sum and the last tag; S2 holds the cast result and drives the outputs.
  - A stage accepts when it is empty or its contents leave this cycle: s2_ready = !s2_valid | data_out_ready; s1_ready = !s1_valid | s2_ready.
  - Latency is 2 cycles from fire to data_out_valid. Throughput is 1 beat/cycle under continuous ready.
  - Output holds stable while data_out_valid & !data_out_ready.
- Counters (advance on fire only):
  - col 0..COL_BEATS-1, wraps to 0.
  - On col wrap, row 0..TENSOR_SIZE_DIM_1-1, wraps to 0.
  - last tag = (col==COL_BEATS-1)&(row==TENSOR_SIZE_DIM_1-1), carried with the data through both stages.
- Arithmetic, per element:
  - Align: b_al = sign-extend(bias) << (DATA_IN_PRECISION_1-BIAS_PRECISION_1).
  - Sum: s = sext(data_in) + b_al, width DATA_IN_PRECISION_0+1, no overflow possible.
  - Cast: with k = DATA_IN_PRECISION_1-DATA_OUT_PRECISION_1, r = (s + (k>0 ? 1<<(k-1) : 0)) >>> k, i.e. round half toward +inf.
  - Saturate: r clamps to [-(2^(DATA_OUT_PRECISION_0-1)), 2^(DATA_OUT_PRECISION_0-1)-1].
  - Any clamp on a beat that enters S2 sets sat_flag, which stays set until rst.
- Boundaries:
  - Stall with both stages full: data_in_ready=bias_ready=0, no counter change.
  - Simultaneous S2 drain and S1 refill in the same cycle is lossless.
  - A bias source with valid held high is consumed only on fire, so its address stays aligned with col.

Test Plan:
- Basic add (defaults): data_in=0x00001800 (1.5), bias=0x0002 (0.25), ready=1 -> data_out=0x000E (1.75) exactly 2 cycles after fire; sat_flag=0.
- Rounding: data_in=0x00000100 (0.0625), bias=0x0000 -> data_out=0x0001; data_in=0x000000FF -> data_out=0x0000.
- Negative: data_in=0xFFFFF000 (-1.0), bias=0xFFFC (-0.5) -> data_out=0xFFF4 (-1.5). Saturation: data_in=0x7FFFFFFF, bias=0x7FFF -> 0x7FFF and sat_flag=1; data_in=0x80000000, bias=0x8000 -> 0x8000.
- Full tensor: stream 128 beats with continuous valids and ready -> 128 outputs in order; data_out_last high only on beat 127. Then a second tensor -> last on its beat 127; col returns to 0.
- Backpressure: data_out_ready toggles randomly 50% and bias_valid is randomly gapped -> no loss or duplication, per-beat values match the model, data_out stable while stalled, and ready never asserts while the other input's valid is low.
- Reset mid-stream: assert rst with both stages full at col=5 -> next cycle data_out_valid=0, sat_flag=0; the following beat is treated as col 0, and the last tag arrives after 128 beats.

Source files
------------

// File: rtl/fixed_linear_bias_add_cast.sv
// Purpose: joins the matmul result stream with the per-column bias stream,
//          adds them element-wise in fixed point, rounds (half toward +inf)
//          and saturates to the output precision. The result goes out over a
//          two-stage valid/ready pipeline. Column/row counters tag the final
//          beat of each tensor.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   data_in / _valid / _ready     matmul results, PARALLELISM lanes
//   bias / _valid / _ready        bias beat, consumed together with data_in
//   data_out / _valid / _ready    biased, cast result
//   data_out_last                 final beat of the tensor
//   sat_flag                      sticky: some element clamped since reset
module fixed_linear_bias_add_cast #(
  parameter int unsigned DATA_IN_PRECISION_0  = 32,
  parameter int unsigned DATA_IN_PRECISION_1  = 12,
  parameter int unsigned BIAS_PRECISION_0     = 16,
  parameter int unsigned BIAS_PRECISION_1     = 3,
  parameter int unsigned DATA_OUT_PRECISION_0 = 16,
  parameter int unsigned DATA_OUT_PRECISION_1 = 3,
  parameter int unsigned PARALLELISM          = 1,
  parameter int unsigned TENSOR_SIZE_DIM_0    = 32,
  parameter int unsigned TENSOR_SIZE_DIM_1    = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [PARALLELISM-1:0][DATA_IN_PRECISION_0-1:0]    data_in,
  input  logic                                               data_in_valid,
  output logic                                               data_in_ready,
  input  logic [PARALLELISM-1:0][BIAS_PRECISION_0-1:0]       bias,
  input  logic                                               bias_valid,
  output logic                                               bias_ready,
  output logic [PARALLELISM-1:0][DATA_OUT_PRECISION_0-1:0]   data_out,
  output logic                                               data_out_valid,
  input  logic                                               data_out_ready,
  output logic                                               data_out_last,
  output logic                                               sat_flag
);

  localparam int unsigned DIN_W     = DATA_IN_PRECISION_0;
  localparam int unsigned B_W       = BIAS_PRECISION_0;
  localparam int unsigned DOUT_W    = DATA_OUT_PRECISION_0;
  localparam int unsigned SUM_W     = DIN_W + 1;
  localparam int unsigned RND_W     = SUM_W + 1;
  localparam int unsigned B_SHIFT   = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
  localparam int unsigned K         = DATA_IN_PRECISION_1 - DATA_OUT_PRECISION_1;
  localparam int unsigned COL_BEATS = TENSOR_SIZE_DIM_0 / PARALLELISM;
  localparam int unsigned COL_W     = (COL_BEATS > 1) ? $clog2(COL_BEATS) : 1;
  localparam int unsigned ROW_W     = (TENSOR_SIZE_DIM_1 > 1) ? $clog2(TENSOR_SIZE_DIM_1) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_BEATS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TENSOR_SIZE_DIM_1 - 1);

  // Half-LSB of the output grid, expressed at input precision.
  localparam logic [RND_W-1:0] RND_C = (K > 0) ? (RND_W'(1) << ((K > 0) ? (K - 1) : 0)) : RND_W'(0);
  localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((64'sd1 <<< (DOUT_W - 1)) - 64'sd1);
  localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;

  logic                                   s1_valid_q, s1_valid_d;
  logic [PARALLELISM-1:0][SUM_W-1:0]      s1_sum_q, s1_sum_d;
  logic                                   s1_last_q, s1_last_d;
  logic                                   s2_valid_q, s2_valid_d;
  logic [PARALLELISM-1:0][DOUT_W-1:0]     s2_data_q, s2_data_d;
  logic                                   s2_last_q, s2_last_d;
  logic                                   sat_q, sat_d;
  logic [COL_W-1:0]                       col_q, col_d;
  logic [ROW_W-1:0]                       row_q, row_d;

  logic                                   s1_ready, s2_ready, fire, last_tag;
  logic [PARALLELISM-1:0][SUM_W-1:0]      sum_c;
  logic [PARALLELISM-1:0][DOUT_W-1:0]     cast_c;
  logic [PARALLELISM-1:0]                 sat_el;

  // Stage acceptance: empty, or its content leaves this cycle.
  assign s2_ready      = !s2_valid_q | data_out_ready;
  assign s1_ready      = !s1_valid_q | s2_ready;
  assign fire          = data_in_valid & bias_valid & s1_ready;
  assign data_in_ready = bias_valid & s1_ready;
  assign bias_ready    = data_in_valid & s1_ready;
  assign last_tag      = (col_q == COL_LAST) & (row_q == ROW_LAST);

  // Per-lane align/add (into S1) and round/saturate (out of S1).
  for (genvar g = 0; g < PARALLELISM; g++) begin : g_lane
    logic signed [SUM_W-1:0] din_ext, bias_al;
    logic signed [RND_W-1:0] rnd, shr;
    logic                    ovf, udf;

    assign din_ext   = {data_in[g][DIN_W-1], data_in[g]};
    assign bias_al   = {{(SUM_W - B_W){bias[g][B_W-1]}}, bias[g]} << B_SHIFT;
    assign sum_c[g]  = din_ext + bias_al;

    assign rnd       = {s1_sum_q[g][SUM_W-1], s1_sum_q[g]} + RND_C;
    assign shr       = rnd >>> K;
    assign ovf       = shr > OUT_MAX;
    assign udf       = shr < OUT_MIN;
    assign sat_el[g] = ovf | udf;
    assign cast_c[g] = ovf ? OUT_MAX[DOUT_W-1:0] :
                       udf ? OUT_MIN[DOUT_W-1:0] : shr[DOUT_W-1:0];
  end

  // Tensor position; advances only when both beats are consumed.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (fire) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Pipeline next state; sat is sampled as a beat moves S1 -> S2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_last_d  = s2_last_q;
    sat_d      = sat_q;
    if (s1_ready) begin
      s1_valid_d = fire;
      if (fire) begin
        s1_sum_d  = sum_c;
        s1_last_d = last_tag;
      end
    end
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        s2_data_d = cast_c;
        sat_d     = sat_q | (|sat_el);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      sat_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_last_q  <= s2_last_d;
      sat_q      <= sat_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  assign data_out       = s2_data_q;
  assign data_out_valid = s2_valid_q;
  assign data_out_last  = s2_last_q;
  assign sat_flag       = sat_q;

endmodule
